rf_cmd_master: RTL and testbench
================================

Name: rf_cmd_master

Overview:
- Upstream bus master for the HMC controller register-file port.
- Accepts a valid/ready command stream (read/write, address, data) and buffers it in a small FIFO.
- Drives one RF access at a time, waits for completion, invalid-address or timeout, then returns a response (read data + error code) on a valid/ready response stream.
- Sits between test/host logic and the controller RF interface; it is the only driver of the rf_* request signals.

Parameters:
- ADDR_W, 4, RF address width.
- DATA_W, 64, RF data width.
- CMD_DEPTH, 4, command FIFO depth; power of two, ≥2.
- TIMEOUT_CYC, 64, cycles in WAIT without a terminating event before a timeout response; ≥2.

Ports:
- clk_hmc  in  1  single clock; everything is rising-edge.
- res_hmc  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target RF address.
- cmd_wdata  in  DATA_W  write value; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  2  00 OK, 01 INVALID_ADDR, 10 TIMEOUT.
- rf_write_data  out  DATA_W  value to write.
- rf_read_data  in  DATA_W  valid when rf_access_complete=1.
- rf_address  out  ADDR_W  access address.
- rf_read_en  out  1  read request pulse.
- rf_write_en  out  1  write request pulse.
- rf_invalid_address  in  1  address out of range; terminates access.
- rf_access_complete  in  1  successful termination.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: one clock `clk_hmc`; reset `res_hmc` is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1. FIFO is emptied and FSM goes to IDLE. Reset mid-access abandons the access; no response is produced.
- FIFO: a command is accepted when cmd_valid & cmd_ready. cmd_ready = !full and is registered-path clean (no combinational path from rsp_ready). A simultaneous push and pop when full is not accepted, because cmd_ready was already 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the access register and go to ISSUE.
  - First issue occurs 2 cycles after acceptance into an empty FIFO.
- ISSUE:
  - rf_address/rf_write_data are driven from the access register.
  - Exactly one of rf_read_en/rf_write_en is high for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - rf_address/rf_write_data are held stable and enables are 0.
  - Each cycle, in priority order:
    1. rf_invalid_address=1 → err=01, rdata=0.
    2. rf_access_complete=1 → err=00; rdata = rf_read_data for reads, 0 for writes.
    3. Counter reaches TIMEOUT_CYC-1 → err=10, rdata=0.
    4. Otherwise increment the counter.
  - Cases 1–3 go to RESP.
  - Complete on the same cycle the counter expires is OK, not timeout.
  - Complete/invalid in the ISSUE cycle itself is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err are stable while rsp_valid & !rsp_ready.
  - On rsp_ready, go to IDLE, or directly to ISSUE if the FIFO is non-empty (pop that cycle).
- Back-to-back: minimum spacing is 3 cycles between consecutive enables when rsp_ready is tied high and completion comes 1 cycle after enable.
- Stray rf_access_complete/rf_invalid_address outside WAIT is ignored.
- Responses are returned strictly in command order.

Optional Feature:
- Macro `RF_CMD_MASTER_STATS_EN`.
- Defined:
  - Adds outputs stat_ok, stat_inval and stat_tmo, each 16-bit.
  - Each counter increments on its response handshake (rsp_valid & rsp_ready) and saturates at 0xFFFF.
  - All counters reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package rf_cmd_pkg contains:
  - rsp_err_e enum (ERR_OK=2'b00, ERR_INVAL=2'b01, ERR_TMO=2'b10).
  - state_e enum (IDLE, ISSUE, WAIT, RESP).
  - rf_cmd_t packed struct {write, addr, wdata}.
  - Default parameter constants.
- Sub-module rf_cmd_fifo: synchronous FIFO of rf_cmd_t with push/pop/full/empty.
- FSM, timeout counter and stats counters live in the top module.

Test Plan:
- Write 0x0123_4567_89AB_CDEF to addr 0x2, complete 1 cycle after rf_write_en → one-cycle rf_write_en with rf_address=2; rsp err=00, rdata=0.
- Read addr 0x5, complete after 3 cycles with rf_read_data=0xDEAD_BEEF → rsp err=00, rdata=0xDEAD_BEEF; rf_read_en high exactly 1 cycle.
- Read addr 0xF with rf_invalid_address=1 and rf_access_complete=1 in the same cycle → err=01, rdata=0.
- Read with no RF reply, TIMEOUT_CYC=64 → rsp_valid rises 64 cycles after leaving ISSUE, err=10. Then a late rf_access_complete is ignored.
- Push 5 commands back-to-back with rsp_ready=0 → cmd_ready drops after 4+1 accepted; the first response stays stable until rsp_ready. Responses then drain in order.
- Assert res_hmc during WAIT → next cycle all outputs are at reset values, no response, busy=0, and the FIFO is empty.

Source files
------------

// File: rtl/rf_cmd_pkg.sv
// rf_cmd_pkg: shared types and default parameters for the RF command master.
//   rsp_err_e : response error code placed on rsp_err
//   state_e   : access sequencer states
//   rf_cmd_t  : one buffered command {write, addr, wdata}
package rf_cmd_pkg;

    localparam int RF_ADDR_W      = 4;
    localparam int RF_DATA_W      = 64;
    localparam int RF_CMD_DEPTH   = 4;
    localparam int RF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_INVAL = 2'b01,
        ERR_TMO   = 2'b10
    } rsp_err_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic                 write;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] wdata;
    } rf_cmd_t;

endpackage

// File: rtl/rf_cmd_master_if.sv
// rf_cmd_master_if: command stream, response stream and RF request/reply bus.
//   cmd_*  : valid/ready command stream (host -> master)
//   rsp_*  : valid/ready response stream (master -> host)
//   rf_*   : register-file request (master -> controller) and reply
// Modports: master = the rf_cmd_master side, slave = host + RF side.
interface rf_cmd_master_if
    import rf_cmd_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;

    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_read_data;
    logic [ADDR_W-1:0] rf_address;
    logic              rf_read_en;
    logic              rf_write_en;
    logic              rf_invalid_address;
    logic              rf_access_complete;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output rf_write_data, rf_address, rf_read_en, rf_write_en,
        input  rf_read_data, rf_invalid_address, rf_access_complete
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  rf_write_data, rf_address, rf_read_en, rf_write_en,
        output rf_read_data, rf_invalid_address, rf_access_complete
    );

endinterface

// File: rtl/rf_cmd_fifo.sv
// rf_cmd_fifo: synchronous FIFO of rf_cmd_t commands.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write din when not full
//   pop, dout   : dout is the head entry; pop advances when not empty
//   full, empty : occupancy flags, derived from registered pointers only
module rf_cmd_fifo
    import rf_cmd_pkg::*;
#(
    parameter int DEPTH = RF_CMD_DEPTH
)(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  rf_cmd_t din,
    input  logic    pop,
    output rf_cmd_t dout,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH);

    rf_cmd_t       mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_cmd_master.sv
// rf_cmd_master: buffers RF commands and runs one register-file access at a
// time, returning {rdata, err} responses in command order.
// Ports:
//   clk_hmc  : clock (rising edge)
//   res_hmc  : synchronous active-high reset; abandons any access in flight
//   bus      : rf_cmd_master_if.master (cmd stream, rsp stream, rf_* bus)
//   busy     : commands buffered or an access/response outstanding
//   stat_ok, stat_inval, stat_tmo : saturating 16-bit response counters,
//              present only when RF_CMD_MASTER_STATS_EN is defined
//
// state | meaning
// IDLE  | no access; pops the FIFO head when one is buffered
// ISSUE | one-cycle read/write enable, timeout counter cleared
// WAIT  | address/data held, waiting for invalid/complete/timeout
// RESP  | response presented until rsp_ready
module rf_cmd_master
    import rf_cmd_pkg::*;
#(
    parameter int ADDR_W      = RF_ADDR_W,
    parameter int DATA_W      = RF_DATA_W,
    parameter int CMD_DEPTH   = RF_CMD_DEPTH,
    parameter int TIMEOUT_CYC = RF_TIMEOUT_CYC
)(
    input  logic            clk_hmc,
    input  logic            res_hmc,
    rf_cmd_master_if.master bus,
    output logic            busy
`ifdef RF_CMD_MASTER_STATS_EN
    ,
    output logic [15:0]     stat_ok,
    output logic [15:0]     stat_inval,
    output logic [15:0]     stat_tmo
`endif
);
    localparam int             TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

    rf_cmd_t           fifo_din;
    rf_cmd_t           fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    state_e            state_q;
    state_e            state_d;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [TW-1:0]     tmo_cnt;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              rsp_load;
    logic [DATA_W-1:0] rdata_d;
    rsp_err_e          err_d;
    logic [DATA_W-1:0] rsp_rdata_q;
    rsp_err_e          rsp_err_q;

    assign fifo_din  = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign fifo_push = bus.cmd_valid & ~fifo_full;
    assign bus.cmd_ready = ~fifo_full;

    rf_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk_hmc),
        .rst   (res_hmc),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        rsp_load = 1'b0;
        rdata_d  = '0;
        err_d    = ERR_OK;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Invalid beats complete; complete beats an expiring counter.
                if (bus.rf_invalid_address) begin
                    rsp_load = 1'b1;
                    err_d    = ERR_INVAL;
                    state_d  = RESP;
                end else if (bus.rf_access_complete) begin
                    rsp_load = 1'b1;
                    err_d    = ERR_OK;
                    rdata_d  = acc_write ? '0 : bus.rf_read_data;
                    state_d  = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    rsp_load = 1'b1;
                    err_d    = ERR_TMO;
                    state_d  = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            state_q     <= IDLE;
            acc_write   <= 1'b0;
            acc_addr    <= '0;
            acc_wdata   <= '0;
            tmo_cnt     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                acc_write <= fifo_dout.write;
                acc_addr  <= fifo_dout.addr;
                acc_wdata <= fifo_dout.wdata;
            end
            if (cnt_clr) begin
                tmo_cnt <= '0;
            end else if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (rsp_load) begin
                rsp_rdata_q <= rdata_d;
                rsp_err_q   <= err_d;
            end
        end
    end

    assign bus.rf_address    = acc_addr;
    assign bus.rf_write_data = acc_wdata;
    assign bus.rf_read_en    = (state_q == ISSUE) & ~acc_write;
    assign bus.rf_write_en   = (state_q == ISSUE) &  acc_write;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign busy              = ~fifo_empty | (state_q != IDLE);

`ifdef RF_CMD_MASTER_STATS_EN
    logic rsp_hs;
    assign rsp_hs = (state_q == RESP) & bus.rsp_ready;

    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            stat_ok    <= '0;
            stat_inval <= '0;
            stat_tmo   <= '0;
        end else if (rsp_hs) begin
            if (rsp_err_q == ERR_OK && stat_ok != 16'hFFFF) begin
                stat_ok <= stat_ok + 16'd1;
            end
            if (rsp_err_q == ERR_INVAL && stat_inval != 16'hFFFF) begin
                stat_inval <= stat_inval + 16'd1;
            end
            if (rsp_err_q == ERR_TMO && stat_tmo != 16'hFFFF) begin
                stat_tmo <= stat_tmo + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_cmd_master.sv
// tb_rf_cmd_master: directed, table-driven bench for rf_cmd_master.
// Single-access vectors from a table, then hand-written sequences for FIFO
// back-pressure/ordering and reset during an access.
module tb_rf_cmd_master;
    import rf_cmd_pkg::*;

    logic clk_hmc = 1'b0;
    logic res_hmc = 1'b1;
    logic busy;
`ifdef RF_CMD_MASTER_STATS_EN
    logic [15:0] stat_ok, stat_inval, stat_tmo;
`endif

    rf_cmd_master_if #(.ADDR_W(4), .DATA_W(64)) bus ();

    rf_cmd_master #(.ADDR_W(4), .DATA_W(64), .CMD_DEPTH(4), .TIMEOUT_CYC(64)) dut (
        .clk_hmc (clk_hmc),
        .res_hmc (res_hmc),
        .bus     (bus),
        .busy    (busy)
`ifdef RF_CMD_MASTER_STATS_EN
        ,
        .stat_ok    (stat_ok),
        .stat_inval (stat_inval),
        .stat_tmo   (stat_tmo)
`endif
    );

    always #5 clk_hmc = ~clk_hmc;

    int total = 0;
    int bad   = 0;
    int exp_ok = 0, exp_inval = 0, exp_tmo = 0;

    // kind: 0 complete, 1 invalid, 2 invalid+complete, 3 no reply
    typedef struct {
        logic        write;
        logic [3:0]  addr;
        logic [63:0] wdata;
        int          kind;
        int          delay;
        logic        stray;
        logic [63:0] rd_in;
        logic [1:0]  exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk_hmc);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_model(input logic [3:0] a);
        return 64'hA5A5_0000_0000_0000 | {60'h0, a} | ({60'h0, a} << 32);
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        int k;
        bit got;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        lat = 0;
        do begin
            step();
            lat++;
            bus.cmd_valid = 1'b0;
        end while (!(bus.rf_read_en || bus.rf_write_en) && lat < 10);
        check("issue_lat", 64'(lat), 64'd2);
        check("wr_en", {63'h0, bus.rf_write_en}, {63'h0, v.write});
        check("rd_en", {63'h0, bus.rf_read_en}, {63'h0, !v.write});
        check("rf_addr", {60'h0, bus.rf_address}, {60'h0, v.addr});
        if (v.write) check("rf_wdata", bus.rf_write_data, v.wdata);
        if (v.stray) begin
            bus.rf_access_complete = 1'b1;
            bus.rf_read_data       = 64'h5555_5555_5555_5555;
        end
        k = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            step();
            k++;
            bus.rf_access_complete = 1'b0;
            bus.rf_invalid_address = 1'b0;
            if (k == 1) check("en_pulse", {63'h0, bus.rf_read_en | bus.rf_write_en}, 64'd0);
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else if (k == v.delay && v.kind != 3) begin
                bus.rf_read_data       = v.rd_in;
                bus.rf_access_complete = (v.kind == 0 || v.kind == 2);
                bus.rf_invalid_address = (v.kind == 1 || v.kind == 2);
            end
        end
        check("rsp_lat", 64'(k), 64'(v.exp_lat));
        check("rsp_err", {62'h0, bus.rsp_err}, {62'h0, v.exp_err});
        check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        check("addr_hold", {60'h0, bus.rf_address}, {60'h0, v.addr});
        if (v.exp_err == 2'b00) exp_ok++;
        else if (v.exp_err == 2'b01) exp_inval++;
        else exp_tmo++;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", {63'h0, bus.rsp_valid}, 64'd0);
    endtask

    initial begin
        int n, acc, idx, cyc, last_en;
        bit pend, saw_en, saw_rsp;
        logic [63:0] first_rdata;

        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 0; bus.rf_read_data = '0;
        bus.rf_invalid_address = 0; bus.rf_access_complete = 0;

        //            wr    addr   wdata                   kind dly stray rd_in                    err    rdata                   lat
        vecs[0] = '{1'b1, 4'h2, 64'h0123_4567_89AB_CDEF, 0,  1, 1'b0, 64'h0,                   2'b00, 64'h0,                   2};
        vecs[1] = '{1'b0, 4'h5, 64'h0,                   0,  3, 1'b0, 64'hDEAD_BEEF,           2'b00, 64'hDEAD_BEEF,           4};
        vecs[2] = '{1'b0, 4'hF, 64'h0,                   2,  1, 1'b0, 64'h1234,                2'b01, 64'h0,                   2};
        vecs[3] = '{1'b0, 4'h7, 64'h0,                   3,  0, 1'b0, 64'h0,                   2'b10, 64'h0,                  65};
        vecs[4] = '{1'b1, 4'h3, 64'hFFFF_0000_FFFF_0000, 1,  2, 1'b0, 64'h0,                   2'b01, 64'h0,                   3};
        vecs[5] = '{1'b0, 4'h0, 64'h0,                   0,  1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        vecs[6] = '{1'b1, 4'h9, 64'h0000_0000_0000_0042, 0,  1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 2'b00, 64'h0,                   2};
        vecs[7] = '{1'b0, 4'h1, 64'h0,                   0,  2, 1'b1, 64'h77,                  2'b00, 64'h77,                  3};
        vecs[8] = '{1'b0, 4'hC, 64'h0,                   0, 64, 1'b0, 64'hC0FF_EE00,           2'b00, 64'hC0FF_EE00,          65};

        repeat (3) step();
        res_hmc = 1'b0;
        step();

        check("rst_cmd_ready", {63'h0, bus.cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'h0, bus.rsp_valid}, 64'd0);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_en", {62'h0, bus.rf_read_en, bus.rf_write_en}, 64'd0);
        check("rst_addr", {60'h0, bus.rf_address}, 64'd0);
        check("rst_wdata", bus.rf_write_data, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // A late complete after the timeout, with nothing in flight.
        bus.rf_access_complete = 1'b1;
        bus.rf_read_data = 64'h1111;
        step();
        bus.rf_access_complete = 1'b0;
        step();
        check("late_cmpl_rsp", {63'h0, bus.rsp_valid}, 64'd0);
        check("late_cmpl_busy", {63'h0, busy}, 64'd0);

        // Six commands offered with rsp_ready low: one in flight + four buffered.
        n = 0; acc = 0; pend = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.cmd_valid = (n < 6);
            bus.cmd_write = 1'b0;
            bus.cmd_addr  = 4'(n + 1);
            bus.cmd_wdata = '0;
            bus.rf_access_complete = pend;
            bus.rf_read_data = rd_model(bus.rf_address);
            pend = bus.rf_read_en | bus.rf_write_en;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc++;
                n++;
            end
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rf_access_complete = 1'b0;
        check("accepted", 64'(acc), 64'd5);
        check("full_ready", {63'h0, bus.cmd_ready}, 64'd0);
        check("stall_valid", {63'h0, bus.rsp_valid}, 64'd1);
        first_rdata = bus.rsp_rdata;
        check("stall_rdata", first_rdata, rd_model(4'h1));
        repeat (3) step();
        check("stable_valid", {63'h0, bus.rsp_valid}, 64'd1);
        check("stable_rdata", bus.rsp_rdata, rd_model(4'h1));
        check("stable_err", {62'h0, bus.rsp_err}, 64'd0);

        bus.rsp_ready = 1'b1;
        idx = 0; cyc = 0; last_en = -1; pend = 1'b0;
        while (idx < 5 && cyc < 80) begin
            bus.rf_access_complete = pend;
            bus.rf_read_data = rd_model(bus.rf_address);
            pend = bus.rf_read_en | bus.rf_write_en;
            if (pend) begin
                if (last_en >= 0) check("b2b_gap", 64'(cyc - last_en), 64'd3);
                last_en = cyc;
            end
            if (bus.rsp_valid) begin
                check("order_rdata", bus.rsp_rdata, rd_model(4'(idx + 1)));
                idx++;
            end
            step();
            cyc++;
        end
        bus.rsp_ready = 1'b0;
        bus.rf_access_complete = 1'b0;
        exp_ok += 5;
        check("drained", 64'(idx), 64'd5);
        step();
        check("drain_busy", {63'h0, busy}, 64'd0);

`ifdef RF_CMD_MASTER_STATS_EN
        check("stat_ok", {48'h0, stat_ok}, 64'(exp_ok));
        check("stat_inval", {48'h0, stat_inval}, 64'(exp_inval));
        check("stat_tmo", {48'h0, stat_tmo}, 64'(exp_tmo));
`endif

        // Reset while an access is in WAIT and a second command is buffered.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h6;
        step();
        bus.cmd_addr = 4'h8;
        step();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.rf_read_en || bus.rf_write_en) && n < 10) begin
            step();
            n++;
        end
        check("rst_seq_issue", {60'h0, bus.rf_address}, 64'h6);
        step();
        step();
        res_hmc = 1'b1;
        step();
        check("mid_rst_ready", {63'h0, bus.cmd_ready}, 64'd1);
        check("mid_rst_valid", {63'h0, bus.rsp_valid}, 64'd0);
        check("mid_rst_busy", {63'h0, busy}, 64'd0);
        check("mid_rst_addr", {60'h0, bus.rf_address}, 64'd0);
        check("mid_rst_rdata", bus.rsp_rdata, 64'd0);
        check("mid_rst_err", {62'h0, bus.rsp_err}, 64'd0);
`ifdef RF_CMD_MASTER_STATS_EN
        check("mid_rst_stat", {16'h0, stat_ok, stat_inval, stat_tmo}, 64'd0);
`endif
        res_hmc = 1'b0;
        saw_en = 1'b0; saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.rf_access_complete = (c == 2);
            step();
            saw_en  |= bus.rf_read_en | bus.rf_write_en;
            saw_rsp |= bus.rsp_valid;
        end
        bus.rf_access_complete = 1'b0;
        check("post_rst_no_issue", {63'h0, saw_en}, 64'd0);
        check("post_rst_no_rsp", {63'h0, saw_rsp}, 64'd0);
        check("post_rst_busy", {63'h0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
